// File: rtl/alu_vector_sequencer.sv
// ---------------------------------------------------------------------------
// alu_vector_sequencer
//
// Issue-side controller for the 8-bit lane ALU. Accepts one packed vector
// instruction over a valid/ready handshake, feeds the ALU one lane per cycle,
// gathers the per-lane results into a packed register and returns the whole
// vector over a second valid/ready handshake.
//
// Parameters
//   BITS   lane/element width (must match the ALU)
//   ALUOP  opcode width (must match the ALU)
//   LANES  elements per vector (>= 2)
//
// Ports
//   clk, rst_n                clock (rising edge), async active-low reset
//   instValid/instReady       instruction handshake
//   instOp/instA/instB        opcode and packed operands (lane k = [k*BITS +: BITS])
//   instScalar                1 = broadcast instB lane 0 to every lane
//   aluOP/vectorA/vectorB     per-lane drive to the ALU (all 0 when idle)
//   aluResult                 ALU result for the lane being driven
//   resValid/resReady         result handshake
//   resData                   packed result, same lane order as instA
//   resIllegal                opcode outside 1..10 (qualified by resValid)
//   busy                      sequencer not idle
//
// Build option
//   ALU_SEQ_PIPE_EN  ALU result is registered: lane k is captured one edge
//                    later and a DRAIN state follows the last ISSUE lane.
// ---------------------------------------------------------------------------
module alu_vector_sequencer #(
    parameter int BITS  = 8,
    parameter int ALUOP = 4,
    parameter int LANES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    instValid,
    output logic                    instReady,
    input  logic [ALUOP-1:0]        instOp,
    input  logic [LANES*BITS-1:0]   instA,
    input  logic [LANES*BITS-1:0]   instB,
    input  logic                    instScalar,
    output logic [ALUOP-1:0]        aluOP,
    output logic [BITS-1:0]         vectorA,
    output logic [BITS-1:0]         vectorB,
    input  logic [BITS-1:0]         aluResult,
    output logic                    resValid,
    input  logic                    resReady,
    output logic [LANES*BITS-1:0]   resData,
    output logic                    resIllegal,
    output logic                    busy
);

    localparam int unsigned VW = LANES * BITS;
    localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
`ifdef ALU_SEQ_PIPE_EN
        ,
        S_DRAIN = 2'd3
`endif
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [ALUOP-1:0]   r_op;
    logic [VW-1:0]      r_a;
    logic [VW-1:0]      r_b;
    logic               r_scalar;
    logic [LW-1:0]      r_lane;
    logic [VW-1:0]      r_res;
    logic               r_ill;

    logic               w_accept;
    logic               w_legal;
    logic               w_last;
    logic               w_cap_en;
    logic [LW-1:0]      w_cap_lane;
    logic [BITS-1:0]    w_lane_a;
    logic [BITS-1:0]    w_lane_b;

    assign w_accept = instValid && (r_state == S_IDLE);
    assign w_legal  = (instOp != '0) && (32'(instOp) <= 32'd10);
    assign w_last   = (r_lane == LAST_LANE);

    // Lane operand select from the latched vectors
    always_comb begin
        w_lane_a = '0;
        w_lane_b = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (r_lane == LW'(k)) begin
                w_lane_a = r_a[k*BITS +: BITS];
                w_lane_b = r_b[k*BITS +: BITS];
            end
        end
    end

    // Which lane of resData receives aluResult on the coming edge
`ifdef ALU_SEQ_PIPE_EN
    // Registered ALU: the sample arriving now belongs to the previous lane;
    // DRAIN collects the final lane while its operands are still driven.
    always_comb begin
        w_cap_en   = 1'b0;
        w_cap_lane = r_lane;
        if (r_state == S_ISSUE && r_lane != '0) begin
            w_cap_en   = 1'b1;
            w_cap_lane = r_lane - LW'(1);
        end else if (r_state == S_DRAIN) begin
            w_cap_en   = 1'b1;
            w_cap_lane = r_lane;
        end
    end
`else
    assign w_cap_en   = (r_state == S_ISSUE);
    assign w_cap_lane = r_lane;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_legal ? S_ISSUE : S_DONE;
                end
            end
            S_ISSUE: begin
                if (w_last) begin
`ifdef ALU_SEQ_PIPE_EN
                    w_next = S_DRAIN;
`else
                    w_next = S_DONE;
`endif
                end
            end
`ifdef ALU_SEQ_PIPE_EN
            S_DRAIN: w_next = S_DONE;
`endif
            S_DONE: begin
                if (resReady) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        instReady = 1'b0;
        resValid  = 1'b0;
        busy      = 1'b1;
        aluOP     = '0;
        vectorA   = '0;
        vectorB   = '0;
        case (r_state)
            S_IDLE: begin
                instReady = 1'b1;
                busy      = 1'b0;
            end
            S_ISSUE: begin
                aluOP   = r_op;
                vectorA = w_lane_a;
                vectorB = r_scalar ? r_b[BITS-1:0] : w_lane_b;
            end
`ifdef ALU_SEQ_PIPE_EN
            S_DRAIN: begin
                aluOP   = r_op;
                vectorA = w_lane_a;
                vectorB = r_scalar ? r_b[BITS-1:0] : w_lane_b;
            end
`endif
            S_DONE: begin
                resValid = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    assign resData    = r_res;
    assign resIllegal = r_ill;

    // Instruction latch, lane counter and result collection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_scalar <= 1'b0;
            r_lane   <= '0;
            r_res    <= '0;
            r_ill    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op     <= instOp;
                r_a      <= instA;
                r_b      <= instB;
                r_scalar <= instScalar;
                r_res    <= '0;
                r_ill    <= !w_legal;
            end

            if (r_state == S_IDLE) begin
                r_lane <= '0;
            end else if (r_state == S_ISSUE && !w_last) begin
                r_lane <= r_lane + LW'(1);
            end

            if (w_cap_en) begin
                for (int unsigned k = 0; k < LANES; k++) begin
                    if (w_cap_lane == LW'(k)) begin
                        r_res[k*BITS +: BITS] <= aluResult;
                    end
                end
            end

            if (r_state == S_DONE && resReady) begin
                r_ill <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_vector_sequencer.sv
module tb_alu_vector_sequencer;

    localparam int BITS  = 8;
    localparam int ALUOP = 4;
    localparam int LANES = 4;
    localparam int VW    = LANES * BITS;
`ifdef ALU_SEQ_PIPE_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic             clk;
    logic             rst_n;
    logic             instValid;
    logic             instReady;
    logic [ALUOP-1:0] instOp;
    logic [VW-1:0]    instA;
    logic [VW-1:0]    instB;
    logic             instScalar;
    logic [ALUOP-1:0] aluOP;
    logic [BITS-1:0]  vectorA;
    logic [BITS-1:0]  vectorB;
    logic [BITS-1:0]  aluResult;
    logic             resValid;
    logic             resReady;
    logic [VW-1:0]    resData;
    logic             resIllegal;
    logic             busy;

    alu_vector_sequencer #(.BITS(BITS), .ALUOP(ALUOP), .LANES(LANES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instValid  (instValid),
        .instReady  (instReady),
        .instOp     (instOp),
        .instA      (instA),
        .instB      (instB),
        .instScalar (instScalar),
        .aluOP      (aluOP),
        .vectorA    (vectorA),
        .vectorB    (vectorB),
        .aluResult  (aluResult),
        .resValid   (resValid),
        .resReady   (resReady),
        .resData    (resData),
        .resIllegal (resIllegal),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural lane ALU: 2 add, 3 sub, 7 shift left, 9 rotate left
    function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [2:0] s;
        s = b[2:0];
        case (op)
            4'd2:    return a + b;
            4'd3:    return a - b;
            4'd7:    return a << s;
            4'd9:    return (a << s) | (a >> (4'd8 - {1'b0, s}));
            4'd0:    return 8'h00;
            default: return a ^ b;
        endcase
    endfunction

`ifdef ALU_SEQ_PIPE_EN
    always @(posedge clk) aluResult <= alu_f(aluOP, vectorA, vectorB);
`else
    always_comb aluResult = alu_f(aluOP, vectorA, vectorB);
`endif

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        sc;
        logic [31:0] exp_data;
        logic        exp_ill;
        int          hold;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   checks;
    int   errors;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] lane_of(input logic [31:0] v, input int l);
        return v[l*8 +: 8];
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_instReady"},  instReady,  1);
        check({tag, "_resValid"},   resValid,   0);
        check({tag, "_busy"},       busy,       0);
        check({tag, "_resData"},    resData,    0);
        check({tag, "_resIllegal"}, resIllegal, 0);
        check({tag, "_aluOP"},      aluOP,      0);
        check({tag, "_vectorA"},    vectorA,    0);
        check({tag, "_vectorB"},    vectorB,    0);
    endtask

    task automatic run_inst(input vec_t v);
        int   n;
        int   opcnt;
        int   lane_ok;
        int   hold_ok;
        int   l;
        int   exp_cycles;
        exp_t e;
        logic [31:0] held;

        @(negedge clk);
        instValid  = 1'b1;
        instOp     = v.op;
        instA      = v.a;
        instB      = v.b;
        instScalar = v.sc;
        sb.push_back('{v.exp_data, v.exp_ill});
        @(posedge clk);
        #1;
        // Scramble inputs after acceptance; only the latched copy may matter
        instValid  = 1'b0;
        instOp     = 4'hF;
        instA      = ~v.a;
        instB      = ~v.b;
        instScalar = ~v.sc;

        @(negedge clk);
        n       = 0;
        opcnt   = 0;
        lane_ok = 0;
        while (!resValid && n < 20) begin
            l = (n < LANES) ? n : LANES - 1;
            if (aluOP == v.op) opcnt++;
            if (vectorA == lane_of(v.a, l) &&
                vectorB == (v.sc ? v.b[7:0] : lane_of(v.b, l))) lane_ok++;
            n++;
            @(negedge clk);
        end
        exp_cycles = v.exp_ill ? 0 : LANES + EXTRA;
        check("latency_edges", n, exp_cycles);
        check("aluop_cycles", opcnt, exp_cycles);
        check("lane_operands", lane_ok, exp_cycles);
        check("done_aluOP", aluOP, 0);

        held    = resData;
        hold_ok = 0;
        for (int i = 0; i < v.hold; i++) begin
            instValid = 1'b1;
            instOp    = 4'd2;
            instA     = 32'h11111111;
            instB     = 32'h22222222;
            @(negedge clk);
            if (resValid && !instReady && busy && resData == held) hold_ok++;
        end
        instValid = 1'b0;
        if (v.hold > 0) check("backpressure_stable", hold_ok, v.hold);

        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            check("resData", resData, e.data);
            check("resIllegal", resIllegal, e.ill);
        end

        resReady = 1'b1;
        @(posedge clk);
        #1;
        resReady = 1'b0;
        @(negedge clk);
        check("post_hs_resValid", resValid, 0);
        check("post_hs_instReady", instReady, 1);
        check("post_hs_resIllegal", resIllegal, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t fresh;
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        instValid  = 1'b0;
        instOp     = '0;
        instA      = '0;
        instB      = '0;
        instScalar = 1'b0;
        resReady   = 1'b0;

        //          op     A             B             sc    result        ill   hold
        vecs[0] = '{4'd2,  32'h04030201, 32'h01010101, 1'b0, 32'h05040302, 1'b0, 0};
        vecs[1] = '{4'd7,  32'h80402010, 32'hFFFFFF01, 1'b1, 32'h00804020, 1'b0, 0};
        vecs[2] = '{4'd3,  32'h00000000, 32'h01010101, 1'b0, 32'hFFFFFFFF, 1'b0, 0};
        vecs[3] = '{4'd12, 32'h12345678, 32'h9ABCDEF0, 1'b0, 32'h00000000, 1'b1, 0};
        vecs[4] = '{4'd0,  32'hDEADBEEF, 32'h01010101, 1'b0, 32'h00000000, 1'b1, 0};
        vecs[5] = '{4'd9,  32'h81818181, 32'h01010101, 1'b0, 32'h03030303, 1'b0, 5};

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("idle");

        for (int i = 0; i < 6; i++) run_inst(vecs[i]);

        // Asynchronous reset while lane 2 is being issued
        @(negedge clk);
        instValid  = 1'b1;
        instOp     = 4'd2;
        instA      = 32'h04030201;
        instB      = 32'h01010101;
        instScalar = 1'b0;
        @(posedge clk);
        #1;
        instValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("midissue_vectorA", vectorA, 8'h03);
        check("midissue_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midissue_reset");
        @(negedge clk);
        rst_n = 1'b1;

        fresh = '{4'd2, 32'h10203040, 32'h01020304, 1'b0, 32'h11223344, 1'b0, 0};
        run_inst(fresh);

        check("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
